// File: rtl/alu.sv
// 64-bit single-cycle ALU. The result of X op Y and the X == Y flag are
// registered every clock, so each result appears exactly one edge after its inputs.
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] X,
    input  logic [63:0] Y,
    input  logic [3:0]  OP,
    output logic [63:0] OUTPUT,
    output logic        isEqual
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_MULH = 4'd9;
    localparam logic [3:0] OP_DIV  = 4'd10;
    localparam logic [3:0] OP_REM  = 4'd11;
    localparam logic [3:0] OP_SLT  = 4'd12;
    localparam logic [3:0] OP_SLTU = 4'd13;

    localparam logic [63:0] INT_MIN = 64'h8000_0000_0000_0000;

    logic [63:0]  result_d, result_q;
    logic         equal_d, equal_q;
    logic [5:0]   shamt;
    logic [127:0] product;
    logic [63:0]  quotient, remainder;
    logic         div_zero, div_ovf;

    assign shamt    = Y[5:0];
    assign product  = {64'd0, X} * {64'd0, Y};
    assign div_zero = (Y == 64'd0);
    assign div_ovf  = (X == INT_MIN) && (Y == {64{1'b1}});

    // Zero divisor and MIN / -1 are steered away from the divider, whose
    // result is undefined for those operands.
    always_comb begin
        quotient  = '0;
        remainder = '0;
        if (div_zero) begin
            quotient  = {64{1'b1}};
            remainder = X;
        end else if (div_ovf) begin
            quotient  = X;
            remainder = '0;
        end else begin
            quotient  = $signed(X) / $signed(Y);
            remainder = $signed(X) % $signed(Y);
        end
    end

    always_comb begin
        result_d = '0;
        equal_d  = (X == Y);
        case (OP)
            OP_ADD:  result_d = X + Y;
            OP_SUB:  result_d = X - Y;
            OP_AND:  result_d = X & Y;
            OP_OR:   result_d = X | Y;
            OP_XOR:  result_d = X ^ Y;
            OP_SLL:  result_d = X << shamt;
            OP_SRL:  result_d = X >> shamt;
            OP_SRA:  result_d = $signed(X) >>> shamt;
            OP_MUL:  result_d = product[63:0];
            OP_MULH: result_d = product[127:64];
            OP_DIV:  result_d = quotient;
            OP_REM:  result_d = remainder;
            OP_SLT:  result_d = {63'd0, ($signed(X) < $signed(Y))};
            OP_SLTU: result_d = {63'd0, (X < Y)};
            default: result_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            equal_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            equal_q  <= equal_d;
        end
    end

    assign OUTPUT  = result_q;
    assign isEqual = equal_q;

endmodule

// File: tb/tb_alu.sv
// Directed bench for the 64-bit ALU: each vector is applied, one edge is taken,
// and OUTPUT / isEqual are compared against hand-computed values.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [63:0] X;
    logic [63:0] Y;
    logic [3:0]  OP;
    logic [63:0] OUTPUT;
    logic        isEqual;

    int n_compared;
    int n_mismatched;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] exp;
        logic        eq;
    } vec_t;

    localparam logic [63:0] ONES    = {64{1'b1}};
    localparam logic [63:0] INT_MIN = 64'h8000_0000_0000_0000;

    alu dut (
        .clk     (clk),
        .rst     (rst),
        .X       (X),
        .Y       (Y),
        .OP      (OP),
        .OUTPUT  (OUTPUT),
        .isEqual (isEqual)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
        OP = op;
        X  = x;
        Y  = y;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(4'd0, 64'd5, 64'd5);
        repeat (2) @(posedge clk);
        #1;
        n_compared++;
        if (OUTPUT !== 64'd0) begin
            n_mismatched++;
            $display("FAIL reset_output: got %h want %h", OUTPUT, 64'd0);
        end
        n_compared++;
        if (isEqual !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reset_isequal: got %b want 0", isEqual);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_compared++;
        if (OUTPUT !== 64'd10) begin
            n_mismatched++;
            $display("FAIL reset_release_output: got %h want %h", OUTPUT, 64'd10);
        end
        n_compared++;
        if (isEqual !== 1'b1) begin
            n_mismatched++;
            $display("FAIL reset_release_isequal: got %b want 1", isEqual);
        end
    endtask

    task automatic test_basic();
        vec_t v[$];
        v.push_back('{"add_5_5",   4'd0, 64'd5,  64'd5,  64'd10, 1'b1});
        v.push_back('{"sub_66_11", 4'd1, 64'd66, 64'd11, 64'd55, 1'b0});
        v.push_back('{"and",       4'd2, 64'd5,  64'd6,  64'd4,  1'b0});
        v.push_back('{"or",        4'd3, 64'd5,  64'd6,  64'd7,  1'b0});
        v.push_back('{"xor",       4'd4, 64'd6,  64'd2,  64'd4,  1'b0});
        v.push_back('{"add_wrap",  4'd0, ONES,   64'd2,  64'd1,  1'b0});
        foreach (v[i]) begin
            drive(v[i].op, v[i].x, v[i].y);
            @(posedge clk);
            #1;
            n_compared++;
            if (OUTPUT !== v[i].exp || isEqual !== v[i].eq) begin
                n_mismatched++;
                $display("FAIL %s: got %h/%b want %h/%b", v[i].name, OUTPUT, isEqual, v[i].exp, v[i].eq);
            end
        end
    endtask

    task automatic test_shifts();
        vec_t v[$];
        v.push_back('{"sll_1_3",    4'd5, 64'd1,   64'd3,  64'd8,  1'b0});
        v.push_back('{"srl_8_2",    4'd6, 64'd8,   64'd2,  64'd2,  1'b0});
        v.push_back('{"sra_m8_2",   4'd7, -64'sd8, 64'd2,  64'hFFFF_FFFF_FFFF_FFFE, 1'b0});
        v.push_back('{"sll_1_64",   4'd5, 64'd1,   64'd64, 64'd1,  1'b0});
        v.push_back('{"srl_hi_y",   4'd6, 64'h100, 64'h0000_0001_0000_0044, 64'h10, 1'b0});
        v.push_back('{"sra_min_63", 4'd7, INT_MIN, 64'd63, ONES,   1'b0});
        v.push_back('{"srl_min_63", 4'd6, INT_MIN, 64'd63, 64'd1,  1'b0});
        foreach (v[i]) begin
            drive(v[i].op, v[i].x, v[i].y);
            @(posedge clk);
            #1;
            n_compared++;
            if (OUTPUT !== v[i].exp || isEqual !== v[i].eq) begin
                n_mismatched++;
                $display("FAIL %s: got %h/%b want %h/%b", v[i].name, OUTPUT, isEqual, v[i].exp, v[i].eq);
            end
        end
    endtask

    task automatic test_multiply();
        vec_t v[$];
        v.push_back('{"mul_6_5",     4'd8, 64'd6,   64'd5, 64'd30, 1'b0});
        v.push_back('{"mulh_min_4",  4'd9, INT_MIN, 64'd4, 64'd2,  1'b0});
        v.push_back('{"mul_ones",    4'd8, ONES,    ONES,  64'd1,  1'b1});
        v.push_back('{"mulh_ones",   4'd9, ONES,    ONES,  64'hFFFF_FFFF_FFFF_FFFE, 1'b1});
        foreach (v[i]) begin
            drive(v[i].op, v[i].x, v[i].y);
            @(posedge clk);
            #1;
            n_compared++;
            if (OUTPUT !== v[i].exp || isEqual !== v[i].eq) begin
                n_mismatched++;
                $display("FAIL %s: got %h/%b want %h/%b", v[i].name, OUTPUT, isEqual, v[i].exp, v[i].eq);
            end
        end
    endtask

    task automatic test_divide();
        vec_t v[$];
        v.push_back('{"div_66_11",   4'd10, 64'd66,  64'd11,  64'd6,   1'b0});
        v.push_back('{"rem_62_3",    4'd11, 64'd62,  64'd3,   64'd2,   1'b0});
        v.push_back('{"div_m7_2",    4'd10, -64'sd7, 64'd2,   -64'sd3, 1'b0});
        v.push_back('{"rem_m7_2",    4'd11, -64'sd7, 64'd2,   ONES,    1'b0});
        v.push_back('{"div_7_m2",    4'd10, 64'd7,   -64'sd2, -64'sd3, 1'b0});
        v.push_back('{"rem_7_m2",    4'd11, 64'd7,   -64'sd2, 64'd1,   1'b0});
        v.push_back('{"div_by_zero", 4'd10, 64'd5,   64'd0,   ONES,    1'b0});
        v.push_back('{"rem_by_zero", 4'd11, 64'd62,  64'd0,   64'd62,  1'b0});
        v.push_back('{"div_ovf",     4'd10, INT_MIN, ONES,    INT_MIN, 1'b0});
        v.push_back('{"rem_ovf",     4'd11, INT_MIN, ONES,    64'd0,   1'b0});
        foreach (v[i]) begin
            drive(v[i].op, v[i].x, v[i].y);
            @(posedge clk);
            #1;
            n_compared++;
            if (OUTPUT !== v[i].exp || isEqual !== v[i].eq) begin
                n_mismatched++;
                $display("FAIL %s: got %h/%b want %h/%b", v[i].name, OUTPUT, isEqual, v[i].exp, v[i].eq);
            end
        end
    endtask

    task automatic test_compare();
        vec_t v[$];
        v.push_back('{"slt_m1_9",  4'd12, ONES,  64'd9, 64'd1, 1'b0});
        v.push_back('{"sltu_m1_9", 4'd13, ONES,  64'd9, 64'd0, 1'b0});
        v.push_back('{"slt_9_m1",  4'd12, 64'd9, ONES,  64'd0, 1'b0});
        v.push_back('{"sltu_9_m1", 4'd13, 64'd9, ONES,  64'd1, 1'b0});
        v.push_back('{"slt_eq",    4'd12, 64'd9, 64'd9, 64'd0, 1'b1});
        v.push_back('{"op14",      4'd14, 64'd3, 64'd4, 64'd0, 1'b0});
        v.push_back('{"op15_eq",   4'd15, 64'd7, 64'd7, 64'd0, 1'b1});
        foreach (v[i]) begin
            drive(v[i].op, v[i].x, v[i].y);
            @(posedge clk);
            #1;
            n_compared++;
            if (OUTPUT !== v[i].exp || isEqual !== v[i].eq) begin
                n_mismatched++;
                $display("FAIL %s: got %h/%b want %h/%b", v[i].name, OUTPUT, isEqual, v[i].exp, v[i].eq);
            end
        end
    endtask

    task automatic test_reset_midstream();
        drive(4'd1, 64'd66, 64'd11);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(4'd0, 64'd5, 64'd5);
        @(posedge clk);
        #1;
        n_compared++;
        if (OUTPUT !== 64'd0 || isEqual !== 1'b0) begin
            n_mismatched++;
            $display("FAIL midstream_reset: got %h/%b want %h/0", OUTPUT, isEqual, 64'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_compared++;
        if (OUTPUT !== 64'd10 || isEqual !== 1'b1) begin
            n_mismatched++;
            $display("FAIL midstream_release: got %h/%b want %h/1", OUTPUT, isEqual, 64'd10);
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst = 1'b1;
        drive(4'd0, 64'd0, 64'd0);
        test_reset();
        test_basic();
        test_shifts();
        test_multiply();
        test_divide();
        test_compare();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
